// File: rtl/gpio_bus_master.sv
//==============================================================================
// Module   : gpio_bus_master
// Purpose  : Command/response bridge issuing single write/read strobes to a
//            simple peripheral port. Optional macro GPIO_BUS_MASTER_VERIFY_EN
//            adds an automatic readback after every write with a mismatch flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gpio_bus_master #(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy
);

    localparam int c_CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state_q;
    logic                cmd_ready_q;
    logic                busy_q;
    logic                wr_en_q;
    logic                rd_en_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [c_CNT_W-1:0]  cnt_q;
`ifdef GPIO_BUS_MASTER_VERIFY_EN
    logic                write_q;
    logic                rsp_err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
`ifdef GPIO_BUS_MASTER_VERIFY_EN
            write_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle pulses; the state that wants one re-arms it.
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef GPIO_BUS_MASTER_VERIFY_EN
                        write_q     <= cmd_write;
`endif
                        if (cmd_write) begin
                            state_q <= S_WRITE;
                            wr_en_q <= 1'b1;
                            wdata_q <= cmd_wdata;
                        end else begin
                            state_q <= S_READ;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
`ifdef GPIO_BUS_MASTER_VERIFY_EN
                    state_q <= S_READ;
                    rd_en_q <= 1'b1;
`else
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
`endif
                end
                S_READ: begin
                    state_q <= S_WAIT;
                    cnt_q   <= c_CNT_W'(READ_LAT);
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata;
`ifdef GPIO_BUS_MASTER_VERIFY_EN
                        // wdata_q still holds the written value, so it doubles as the reference.
                        rsp_err_q   <= write_q && (rdata != wdata_q);
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign wdata     = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef GPIO_BUS_MASTER_VERIFY_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpio_bus_master.sv
//==============================================================================
// Module   : tb_gpio_bus_master
// Purpose  : Self-checking bench for gpio_bus_master (table vectors, directed
//            reset-abort sequence, randomized commands against a memory model).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gpio_bus_master;

`ifdef GPIO_BUS_MASTER_VERIFY_EN
    localparam bit c_VER = 1'b1;
`else
    localparam bit c_VER = 1'b0;
`endif
    localparam int c_RL  = 1;
    localparam int c_RL3 = 3;
    localparam logic [31:0] c_ALL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_write, rsp_ready;
    logic [31:0] cmd_wdata;
    logic [31:0] rdata;
    logic [31:0] mem  = 32'h0;
    logic [31:0] mask = c_ALL;

    logic        cmd_ready, rsp_valid, rsp_err, wr_en, rd_en, busy;
    logic [31:0] rsp_rdata, wdata;
    logic        r3_cmd_ready, r3_rsp_valid, r3_rsp_err, r3_wr_en, r3_rd_en, r3_busy;
    logic [31:0] r3_rsp_rdata, r3_wdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpio_bus_master #(.DATA_W(32), .READ_LAT(c_RL)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata), .rdata(rdata), .busy(busy)
    );

    gpio_bus_master #(.DATA_W(32), .READ_LAT(c_RL3)) u_dut3 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(r3_cmd_ready),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .rsp_valid(r3_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(r3_rsp_rdata), .rsp_err(r3_rsp_err),
        .wr_en(r3_wr_en), .rd_en(r3_rd_en), .wdata(r3_wdata), .rdata(rdata), .busy(r3_busy)
    );

    // Peripheral: a register that keeps only the bits selected by mask.
    always @(posedge clk) if (wr_en) mem <= wdata & mask;
    assign rdata = mem;

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic [31:0] mask;
        int          hold;
        logic        poke;
        logic [31:0] er;
        logic        ee;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_cmd(input vec_t v);
        int n, nwr, nrd, fwr, frd;
        logic got;
        logic [31:0] held;
        mask = v.mask;
        @(negedge clk);
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_wdata = v.d;
        @(posedge clk);
        #1;
        cmd_valid = v.poke;
        cmd_write = 1'b1;
        cmd_wdata = v.poke ? 32'hA : $urandom;
        n = 0; nwr = 0; nrd = 0; fwr = 0; frd = 0; got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (wr_en) begin
                nwr++;
                if (fwr == 0) fwr = n;
                chk("wdata", wdata, v.d);
            end
            if (rd_en) begin
                nrd++;
                if (frd == 0) frd = n;
            end
            chk("strobe_excl", {31'b0, wr_en & rd_en}, 32'd0);
            chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
            got = rsp_valid;
        end
        chk("rsp_latency", n, v.lat);
        chk("wr_pulses", nwr, v.wr ? 1 : 0);
        chk("rd_pulses", nrd, v.wr ? (c_VER ? 1 : 0) : 1);
        if (v.wr) chk("wr_cycle", fwr, 1);
        if (!v.wr || c_VER) chk("rd_cycle", frd, v.wr ? 2 : 1);
        chk("rsp_rdata", rsp_rdata, v.er);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.ee});
        held = rsp_rdata;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, held);
            chk("hold_no_wr", {31'b0, wr_en}, 32'd0);
            chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("done_valid", {31'b0, rsp_valid}, 32'd0);
        chk("done_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("done_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [31:0] mem_ref;
        int wl, rl;
        wl = c_VER ? 3 + c_RL : 2;
        rl = 2 + c_RL;

        tbl[0] = '{1'b1, 32'h0000_0005, c_ALL, 0, 1'b0, c_VER ? 32'h5 : 32'h0, 1'b0, wl};
        tbl[1] = '{1'b0, 32'h0,         c_ALL, 0, 1'b0, 32'h5, 1'b0, rl};
        tbl[2] = '{1'b1, 32'hDEAD_BEEF, c_ALL, 4, 1'b1, c_VER ? 32'hDEAD_BEEF : 32'h0, 1'b0, wl};
        tbl[3] = '{1'b0, 32'h0,         c_ALL, 4, 1'b1, 32'hDEAD_BEEF, 1'b0, rl};
        tbl[4] = '{1'b1, 32'h0000_00FF, 32'hF, 0, 1'b0, c_VER ? 32'h0F : 32'h0, c_VER, wl};
        tbl[5] = '{1'b1, 32'h0000_0005, 32'hF, 1, 1'b0, c_VER ? 32'h05 : 32'h0, 1'b0, wl};
        tbl[6] = '{1'b0, 32'h0,         32'hF, 0, 1'b0, 32'h5, 1'b0, rl};
        tbl[7] = '{1'b0, 32'h0,         c_ALL, 2, 1'b1, 32'h5, 1'b0, rl};

        reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wdata = 32'h1234; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_strobes", {30'b0, wr_en, rd_en}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);

        // rsp_ready while idle must not create a response.
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_rsp_ready", {31'b0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;

        // Reset during WAIT on the READ_LAT=3 instance aborts the read.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("r3_busy_in_wait", {30'b0, r3_busy, r3_rsp_valid}, 32'd2);
        reset = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("r3_abort_ready", {31'b0, r3_cmd_ready}, 32'd1);
        chk("r3_abort_busy", {31'b0, r3_busy}, 32'd0);
        chk("r3_abort_strobes", {30'b0, r3_wr_en, r3_rd_en}, 32'd0);
        chk("r3_abort_rdata", r3_rsp_rdata, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("r3_no_rsp", {31'b0, r3_rsp_valid}, 32'd0);
        end

        for (int i = 0; i < 8; i++) do_cmd(tbl[i]);

        // Random commands against a memory model of the peripheral.
        mem_ref = 32'h5;
        for (int i = 0; i < 100; i++) begin
            v.wr   = 1'($urandom_range(0, 1));
            v.d    = $urandom;
            v.mask = ($urandom_range(0, 3) == 0) ? 32'hF : c_ALL;
            v.hold = $urandom_range(0, 3);
            v.poke = 1'($urandom_range(0, 1));
            if (v.wr) begin
                mem_ref = v.d & v.mask;
                v.er  = c_VER ? mem_ref : 32'h0;
                v.ee  = c_VER && (mem_ref != v.d);
                v.lat = wl;
            end else begin
                v.er  = mem_ref;
                v.ee  = 1'b0;
                v.lat = rl;
            end
            if (v.d == 32'hA) v.d = 32'hB;
            if (v.wr) begin
                mem_ref = v.d & v.mask;
                v.er = c_VER ? mem_ref : 32'h0;
                v.ee = c_VER && (mem_ref != v.d);
            end
            do_cmd(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_bus_master.md
GPIO_BUS_MASTER -- requirements
Module: gpio_bus_master

Interface
REQ-001 Parameter DATA_W, default 32: width of all data buses.
REQ-002 Parameter READ_LAT, default 1, legal range 1..15: cycles from the rd_en cycle to the cycle in which rdata is sampled.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_wdata  input  DATA_W  write data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-011 rsp_rdata  output  DATA_W  read data or readback.
REQ-012 rsp_err  output  1  readback mismatch flag.
REQ-013 wr_en  output  1  peripheral write strobe.
REQ-014 rd_en  output  1  peripheral read strobe.
REQ-015 wdata  output  DATA_W  peripheral write data.
REQ-016 rdata  input  DATA_W  peripheral read data.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, READ, WAIT and RESP, encoded as one registered state.
REQ-019 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch cmd_write and cmd_wdata; next state is WRITE if cmd_write=1, else READ.
REQ-020 WRITE: wr_en=1 for exactly one cycle with wdata equal to the latched data; next state is RESP, or READ when VERIFY_EN is defined.
REQ-021 READ: rd_en=1 for exactly one cycle; next state is WAIT, with the latency counter loaded to READ_LAT.
REQ-022 WAIT: decrement the counter each cycle; in the cycle the counter equals 1, register rdata into rsp_rdata and go to RESP.
REQ-023 RESP: rsp_valid=1, held with rsp_rdata/rsp_err stable until rsp_ready=1; then go to IDLE.
REQ-024 Latency: plain write accepted in cycle 0 gives wr_en in cycle 1 and rsp_valid in cycle 2; read gives rd_en in cycle 1 and rsp_valid in cycle 2+READ_LAT.
REQ-025 cmd_ready SHALL be 0 outside IDLE; cmd_valid while busy is ignored and the command is not latched.
REQ-026 rsp_ready in the first RESP cycle SHALL complete the response in that cycle; cmd_ready returns to 1 in the following cycle, so there are no same-cycle back-to-back transfers.
REQ-027 rsp_ready outside RESP SHALL have no effect.
REQ-028 wr_en and rd_en SHALL never be high in the same cycle.
REQ-029 wdata SHALL hold its last driven value outside WRITE.
REQ-030 A plain write (VERIFY_EN undefined) SHALL return rsp_rdata=0.

Reset
REQ-031 When reset is sampled high, the state SHALL go to IDLE at that edge.
REQ-032 After that edge, cmd_ready=1 and rsp_valid, wr_en, rd_en, busy, rsp_err, rsp_rdata, wdata and the counter SHALL be 0.
REQ-033 Reset in any state, including mid-WAIT or RESP, SHALL abort the transaction with no response issued.
REQ-034 reset SHALL override a simultaneous cmd_valid or rsp_ready.

Configuration
REQ-035 Macro GPIO_BUS_MASTER_VERIFY_EN, when defined, SHALL follow every write with an automatic READ/WAIT readback.
REQ-036 With the macro defined, the readback value SHALL appear on rsp_rdata, and rsp_err SHALL be 1 iff the readback differs from the latched write data.
REQ-037 With the macro defined, write latency SHALL be 3+READ_LAT cycles from acceptance to rsp_valid.
REQ-038 Without the macro, rsp_err SHALL be constant 0 and no readback logic SHALL exist.

Verification
REQ-039 Reset, then write 0x00000005 with rsp_ready=1 -> wr_en high one cycle with wdata=0x5; rsp_valid in cycle 2; rsp_rdata=0.
REQ-040 READ_LAT=1, peripheral model returns 0x00000005 -> rd_en in cycle 1; rsp_valid in cycle 3; rsp_rdata=0x5.
REQ-041 Hold rsp_ready=0 for 4 cycles in RESP, and pulse cmd_valid with data 0xA during busy -> rsp_valid and data held stable; 0xA never written; cmd_ready stays 0.
REQ-042 Assert reset during WAIT with READ_LAT=3 -> next cycle IDLE, cmd_ready=1, no rsp_valid, all strobes 0.
REQ-043 VERIFY_EN defined, write 0xFF with a model that stores only the low nibble -> readback 0x0F, rsp_err=1; write 0x05 -> rsp_err=0.
REQ-044 Run 100 random back-to-back commands -> wr_en and rd_en never both high; each command produces exactly one response, in order.
